pico_bus_arbiter: RTL and testbench
===================================

// Module: pico_bus_arbiter
// PURPOSE
//   Shares one picorv32-style native memory bus slave between two masters.
//   m0 is the CPU; m1 is a secondary master such as a UART boot loader or DMA.
//   The slave is the imem/dmem/peripheral register decoder.
//   Round-robin arbitration; the grant is held for the whole transaction.
//   A watchdog completes hung transactions with an error word, so the CPU never stalls forever.
// PARAMETERS
//   TIMEOUT_CYCLES  256           cycles in BUSY before forced completion; 0 disables the watchdog
//   ERROR_RDATA     32'hDEAD_BEEF rdata returned to a master on timeout
// PORTS
//   clock          in   1   single clock, all logic on posedge
//   reset_n        in   1   synchronous, active-low reset
//   m0_valid       in   1   m0 request; held high until m0_ready
//   m0_instr       in   1   m0 instruction-fetch qualifier
//   m0_addr        in   32  m0 byte address
//   m0_wdata       in   32  m0 write data
//   m0_wstrb       in   4   m0 byte strobes; 0 = read
//   m0_ready       out  1   one-cycle completion pulse to m0
//   m0_rdata       out  32  read data to m0; valid while m0_ready=1
//   m1_*           (same set as m0_*, for m1)
//   s_valid        out  1   request to slave
//   s_instr        out  1   forwarded instr qualifier
//   s_addr         out  32  forwarded byte address
//   s_wdata        out  32  forwarded write data
//   s_wstrb        out  4   forwarded byte strobes
//   s_ready        in   1   slave completion pulse
//   s_rdata        in   32  slave read data
//   err_clear      in   1   clears err_flag and err_master
//   err_flag       out  1   sticky: a timeout has occurred
//   err_master     out  1   master index of the most recent timeout
// BEHAVIOUR
//   States: IDLE, BUSY, TOUT. Registers:
//     - grant (1b)
//     - last_grant (1b, reset 1, so m0 wins the first tie)
//     - wdog counter, width $clog2(TIMEOUT_CYCLES+1)
//   Reset (reset_n=0 at posedge):
//     - state=IDLE, wdog=0, err_flag=0, err_master=0.
//     - All outputs 0 in the cycle after the reset edge, including mid-transaction; any in-flight slave response is dropped.
//   IDLE:
//     - s_valid=0.
//     - One requester: grant it.
//     - Both requesting: grant = ~last_grant.
//     - With a grant, next state is BUSY. Arbitration costs 1 cycle.
//   BUSY:
//     - s_valid = m[grant]_valid.
//     - s_instr/s_addr/s_wdata/s_wstrb follow m[grant] combinationally.
//     - m[grant]_ready = s_ready; m[grant]_rdata = s_rdata.
//     - Non-granted master: ready=0, rdata=0.
//   BUSY exits:
//     - s_ready=1: last_grant<=grant, state<=IDLE, wdog<=0.
//     - m[grant]_valid dropped before ready (protocol error): state<=IDLE, no ready issued, last_grant unchanged.
//     - wdog==TIMEOUT_CYCLES-1 and s_ready=0, watchdog enabled: state<=TOUT.
//     - Otherwise wdog increments.
//     - s_ready wins over timeout when both occur in the same cycle.
//   TOUT (exactly 1 cycle):
//     - s_valid=0; m[grant]_ready=1; m[grant]_rdata=ERROR_RDATA.
//     - err_flag<=1, err_master<=grant, last_grant<=grant.
//     - Then IDLE.
//   err_clear:
//     - Clears err_flag and err_master.
//     - A timeout in the same cycle takes priority: the flag stays set.
//   s_ready outside BUSY is ignored. Never forwarded; no master sees ready outside BUSY/TOUT.
//   A master's request issued in cycle t completes no earlier than t+2 (arb + 1-cycle slave).
//   Back-to-back requests:
//     - One IDLE cycle separates transactions.
//     - Both masters continuously requesting alternate m0,m1,m0...
// TESTING
//   1. m0 read addr 0x0800_0000, slave ready 1 cycle later, rdata=0x1234_5678
//      -> m0_ready pulses at t+2, m0_rdata=0x1234_5678, m1_ready stays 0.
//   2. m0 and m1 both request in the same cycle after reset, both held 4 transactions
//      -> grant order m0,m1,m0,m1; s_addr matches granted master each time.
//   3. m1 write wstrb=4'b0011 to 0x3000_0004, slave never readies, TIMEOUT_CYCLES=8
//      -> m1_ready at 8 cycles in BUSY +1, m1_rdata=0xDEADBEEF, err_flag=1, err_master=1.
//   4. Timeout plus err_clear in the same cycle -> err_flag stays 1.
//      err_clear alone next cycle -> err_flag=0.
//   5. reset_n=0 while BUSY with s_ready arriving in the reset cycle
//      -> no master ready, all outputs 0, next request re-arbitrated with m0 priority.
//   6. Spurious s_ready in IDLE; m0 drops valid mid-BUSY
//      -> no ready to any master, state returns to IDLE.

Source files
------------

// File: rtl/pico_bus_arbiter.sv
// pico_bus_arbiter
//   Two-master arbiter in front of one picorv32-style native memory bus slave.
//   m0 is normally the CPU, m1 a secondary master (boot loader, DMA).
//   Round-robin between the masters; the grant is held for a whole
//   transaction. A watchdog completes a hung transaction with ERROR_RDATA
//   so that no master waits forever on a dead slave.
//
// Parameters
//   TIMEOUT_CYCLES  cycles spent in BUSY before a forced completion (0 = off)
//   ERROR_RDATA     read data returned to the master on a forced completion
//
// Ports
//   clock, reset_n          single clock, synchronous active-low reset
//   m0_* / m1_*             master side: valid/instr/addr/wdata/wstrb in,
//                           ready/rdata out
//   s_*                     slave side: valid/instr/addr/wdata/wstrb out,
//                           ready/rdata in
//   err_clear               clears err_flag and err_master
//   err_flag                sticky, set when a watchdog timeout completes
//   err_master              master index of the most recent timeout
module pico_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERROR_RDATA    = 32'hDEAD_BEEF
) (
    input  logic        clock,
    input  logic        reset_n,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    input  logic        err_clear,
    output logic        err_flag,
    output logic        err_master
);

    // A disabled watchdog still needs a legal (1-bit) counter width.
    localparam int unsigned WDOG_W =
        (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST =
        (TIMEOUT_CYCLES > 0) ? WDOG_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic WDOG_EN = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        TOUT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              grant;
    logic              grant_next;
    logic              last_grant;
    logic              last_grant_next;
    logic [WDOG_W-1:0] wdog;
    logic [WDOG_W-1:0] wdog_next;
    logic              err_flag_next;
    logic              err_master_next;

    // Request of the currently granted master.
    logic              sel_valid;
    logic              sel_instr;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;
    logic [3:0]        sel_wstrb;

    always_comb begin
        if (grant) begin
            sel_valid = m1_valid;
            sel_instr = m1_instr;
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
            sel_wstrb = m1_wstrb;
        end else begin
            sel_valid = m0_valid;
            sel_instr = m0_instr;
            sel_addr  = m0_addr;
            sel_wdata = m0_wdata;
            sel_wstrb = m0_wstrb;
        end
    end

    // State register and the registers that move with it.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;   // m0 wins the first tie after reset
            wdog       <= '0;
            err_flag   <= 1'b0;
            err_master <= 1'b0;
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            last_grant <= last_grant_next;
            wdog       <= wdog_next;
            err_flag   <= err_flag_next;
            err_master <= err_master_next;
        end
    end

    // Next-state logic. The watchdog counter is zero everywhere except while
    // it counts up inside BUSY.
    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_grant_next = last_grant;
        wdog_next       = '0;
        err_flag_next   = err_flag;
        err_master_next = err_master;

        if (err_clear) begin
            err_flag_next   = 1'b0;
            err_master_next = 1'b0;
        end

        unique case (state)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    if (m0_valid && m1_valid) begin
                        grant_next = ~last_grant;
                    end else begin
                        grant_next = m1_valid;
                    end
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (s_ready) begin
                    // Completion beats a simultaneous timeout.
                    last_grant_next = grant;
                    state_next      = IDLE;
                end else if (!sel_valid) begin
                    // Master abandoned its request: drop it silently.
                    state_next = IDLE;
                end else if (WDOG_EN && (wdog == WDOG_LAST)) begin
                    state_next = TOUT;
                end else begin
                    wdog_next = wdog + WDOG_W'(1);
                end
            end
            TOUT: begin
                // A timeout overrides an err_clear in the same cycle.
                err_flag_next   = 1'b1;
                err_master_next = grant;
                last_grant_next = grant;
                state_next      = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs. Gating with reset_n drops a slave response that lands in the
    // reset cycle, so no master sees ready while the arbiter is being reset.
    logic in_busy;
    logic in_tout;

    assign in_busy = reset_n && (state == BUSY);
    assign in_tout = reset_n && (state == TOUT);

    always_comb begin
        s_valid  = 1'b0;
        s_instr  = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        m0_ready = 1'b0;
        m0_rdata = '0;
        m1_ready = 1'b0;
        m1_rdata = '0;

        if (in_busy) begin
            s_valid = sel_valid;
            s_instr = sel_instr;
            s_addr  = sel_addr;
            s_wdata = sel_wdata;
            s_wstrb = sel_wstrb;
            if (grant) begin
                m1_ready = s_ready;
                m1_rdata = s_rdata;
            end else begin
                m0_ready = s_ready;
                m0_rdata = s_rdata;
            end
        end else if (in_tout) begin
            if (grant) begin
                m1_ready = 1'b1;
                m1_rdata = ERROR_RDATA;
            end else begin
                m0_ready = 1'b1;
                m0_rdata = ERROR_RDATA;
            end
        end
    end

endmodule

// File: tb/tb_pico_bus_arbiter.sv
// tb_pico_bus_arbiter
//   Self-checking bench for pico_bus_arbiter with an 8-cycle watchdog.
//   Expected completions (master index + rdata) are queued when a request is
//   driven; a negedge monitor pops and compares them whenever a master sees
//   ready, and flags any ready that no queued request accounts for.
module tb_pico_bus_arbiter;

    logic        clock;
    logic        reset_n;
    logic        m0_valid, m0_instr, m0_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_valid, m1_instr, m1_ready;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        s_valid, s_instr, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        err_clear, err_flag, err_master;

    pico_bus_arbiter #(
        .TIMEOUT_CYCLES (8),
        .ERROR_RDATA    (32'hDEAD_BEEF)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .m0_valid   (m0_valid),
        .m0_instr   (m0_instr),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_wstrb   (m0_wstrb),
        .m0_ready   (m0_ready),
        .m0_rdata   (m0_rdata),
        .m1_valid   (m1_valid),
        .m1_instr   (m1_instr),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_wstrb   (m1_wstrb),
        .m1_ready   (m1_ready),
        .m1_rdata   (m1_rdata),
        .s_valid    (s_valid),
        .s_instr    (s_instr),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_wstrb    (s_wstrb),
        .s_ready    (s_ready),
        .s_rdata    (s_rdata),
        .err_clear  (err_clear),
        .err_flag   (err_flag),
        .err_master (err_master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        master;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next active edge, where inputs are driven.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Completion monitor.
    always @(negedge clock) begin
        if (m0_ready || m1_ready) begin
            check("ready_exclusive", 32'(m0_ready & m1_ready), 32'd0);
            if (sb.size() == 0) begin
                check("spurious_ready", 32'({m1_ready, m0_ready}), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_master", 32'(m1_ready), 32'(mon_e.master));
                check("sb_rdata", m1_ready ? m1_rdata : m0_rdata, mon_e.rdata);
                check("sb_other_rdata", m1_ready ? m0_rdata : m1_rdata, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL sim_bound: simulation did not finish, got running expected finished");
        $fatal(1, "simulation bound exceeded");
    end

    initial begin
        reset_n   = 1'b0;
        m0_valid  = 1'b0; m0_instr = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid  = 1'b0; m1_instr = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        s_ready   = 1'b0; s_rdata = '0;
        err_clear = 1'b0;

        // Reset state
        step();
        step();
        @(negedge clock);
        check("rst_s_valid", 32'(s_valid), 32'd0);
        check("rst_ready", 32'({m1_ready, m0_ready}), 32'd0);
        check("rst_err_flag", 32'(err_flag), 32'd0);
        check("rst_err_master", 32'(err_master), 32'd0);

        // 1: m0 instruction read, slave answers one cycle after s_valid
        step();
        reset_n  = 1'b1;
        m0_valid = 1'b1; m0_instr = 1'b1; m0_addr = 32'h0800_0000; m0_wstrb = 4'b0000;
        sb.push_back('{1'b0, 32'h1234_5678});
        @(negedge clock);
        check("t1_arb_s_valid", 32'(s_valid), 32'd0);
        step();
        @(negedge clock);
        check("t1_s_valid", 32'(s_valid), 32'd1);
        check("t1_s_addr", s_addr, 32'h0800_0000);
        check("t1_s_instr", 32'(s_instr), 32'd1);
        check("t1_early_ready", 32'(m0_ready), 32'd0);
        step();
        s_ready = 1'b1; s_rdata = 32'h1234_5678;
        @(negedge clock);
        check("t1_m0_ready", 32'(m0_ready), 32'd1);
        check("t1_m1_ready", 32'(m1_ready), 32'd0);
        step();
        s_ready = 1'b0; s_rdata = '0; m0_valid = 1'b0; m0_instr = 1'b0;
        @(negedge clock);
        check("t1_after_ready", 32'(m0_ready), 32'd0);

        // 2: both masters request together after reset -> m0,m1,m0,m1
        step();
        reset_n = 1'b0;
        step();
        reset_n  = 1'b1;
        m0_valid = 1'b1; m0_addr = 32'h1000_0000;
        m1_valid = 1'b1; m1_addr = 32'h2000_0000;
        for (int i = 0; i < 4; i++) begin
            logic        g;
            logic [31:0] exp_addr;
            logic [31:0] rd;
            g        = logic'(i % 2);
            exp_addr = (g ? 32'h2000_0000 : 32'h1000_0000) + 32'(i / 2) * 32'd16;
            rd       = 32'hC0DE_0000 + 32'(i);
            sb.push_back('{g, rd});
            @(negedge clock);
            check("t2_arb_idle", 32'(s_valid), 32'd0);
            step();
            @(negedge clock);
            check("t2_s_valid", 32'(s_valid), 32'd1);
            check("t2_s_addr", s_addr, exp_addr);
            step();
            s_ready = 1'b1; s_rdata = rd;
            step();
            s_ready = 1'b0; s_rdata = '0;
            if (g) m1_addr = m1_addr + 32'd16;
            else   m0_addr = m0_addr + 32'd16;
        end
        m0_valid = 1'b0;
        m1_valid = 1'b0;

        // 3: m1 write to a slave that never answers -> watchdog completion
        step();
        m1_valid = 1'b1; m1_addr = 32'h3000_0004; m1_wdata = 32'hCAFE_F00D; m1_wstrb = 4'b0011;
        sb.push_back('{1'b1, 32'hDEAD_BEEF});
        @(negedge clock);
        check("t3_arb_s_valid", 32'(s_valid), 32'd0);
        for (int c = 0; c < 8; c++) begin
            step();
            @(negedge clock);
            check("t3_busy_s_valid", 32'(s_valid), 32'd1);
            check("t3_busy_wstrb", 32'(s_wstrb), 32'h3);
            check("t3_busy_ready", 32'(m1_ready), 32'd0);
        end
        check("t3_s_wdata", s_wdata, 32'hCAFE_F00D);
        step();
        @(negedge clock);
        check("t3_tout_ready", 32'(m1_ready), 32'd1);
        check("t3_tout_rdata", m1_rdata, 32'hDEAD_BEEF);
        check("t3_tout_s_valid", 32'(s_valid), 32'd0);
        step();
        m1_valid = 1'b0; m1_wstrb = '0;
        @(negedge clock);
        check("t3_err_flag", 32'(err_flag), 32'd1);
        check("t3_err_master", 32'(err_master), 32'd1);
        check("t3_idle_ready", 32'(m1_ready), 32'd0);
        step();
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        @(negedge clock);
        check("t3_clr_flag", 32'(err_flag), 32'd0);
        check("t3_clr_master", 32'(err_master), 32'd0);

        // 4: timeout and err_clear in the same cycle -> timeout wins
        step();
        m1_valid = 1'b1; m1_addr = 32'h3000_0008;
        sb.push_back('{1'b1, 32'hDEAD_BEEF});
        repeat (8) step();
        step();
        err_clear = 1'b1;
        @(negedge clock);
        check("t4_tout_ready", 32'(m1_ready), 32'd1);
        step();
        err_clear = 1'b0; m1_valid = 1'b0;
        @(negedge clock);
        check("t4_flag_kept", 32'(err_flag), 32'd1);
        check("t4_master", 32'(err_master), 32'd1);
        step();
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        @(negedge clock);
        check("t4_clr_flag", 32'(err_flag), 32'd0);
        check("t4_clr_master", 32'(err_master), 32'd0);

        // 5: m0 completes (last_grant=0), then reset lands mid-BUSY with s_ready
        step();
        m0_valid = 1'b1; m0_addr = 32'h4000_0000;
        sb.push_back('{1'b0, 32'h5555_AAAA});
        step();
        step();
        s_ready = 1'b1; s_rdata = 32'h5555_AAAA;
        step();
        s_ready = 1'b0; s_rdata = '0; m0_addr = 32'h4000_0004;
        step();
        reset_n = 1'b0; s_ready = 1'b1; s_rdata = 32'hBAD0_BAD0;
        @(negedge clock);
        check("t5_rst_m0_ready", 32'(m0_ready), 32'd0);
        check("t5_rst_s_valid", 32'(s_valid), 32'd0);
        step();
        reset_n = 1'b1; s_ready = 1'b0; s_rdata = '0;
        m1_valid = 1'b1; m1_addr = 32'h5000_0000;
        sb.push_back('{1'b0, 32'h6666_0000});
        @(negedge clock);
        check("t5_post_s_valid", 32'(s_valid), 32'd0);
        check("t5_post_ready", 32'({m1_ready, m0_ready}), 32'd0);
        step();
        @(negedge clock);
        check("t5_rearb_s_valid", 32'(s_valid), 32'd1);
        check("t5_rearb_addr", s_addr, 32'h4000_0004);
        step();
        s_ready = 1'b1; s_rdata = 32'h6666_0000;
        step();
        s_ready = 1'b0; s_rdata = '0; m0_valid = 1'b0; m1_valid = 1'b0;

        // 6: spurious s_ready in IDLE; m0 abandons its request mid-BUSY
        step();
        s_ready = 1'b1; s_rdata = 32'h7777_7777;
        @(negedge clock);
        check("t6_spurious", 32'({m1_ready, m0_ready}), 32'd0);
        step();
        s_ready = 1'b0; s_rdata = '0;
        m0_valid = 1'b1; m0_addr = 32'h6000_0000;
        step();
        @(negedge clock);
        check("t6_busy_s_valid", 32'(s_valid), 32'd1);
        step();
        m0_valid = 1'b0;
        @(negedge clock);
        check("t6_drop_s_valid", 32'(s_valid), 32'd0);
        check("t6_drop_ready", 32'(m0_ready), 32'd0);
        step();
        m1_valid = 1'b1; m1_addr = 32'h7000_0000;
        sb.push_back('{1'b1, 32'h8888_0000});
        @(negedge clock);
        check("t6_idle_s_valid", 32'(s_valid), 32'd0);
        step();
        @(negedge clock);
        check("t6_m1_s_valid", 32'(s_valid), 32'd1);
        check("t6_m1_s_addr", s_addr, 32'h7000_0000);
        step();
        s_ready = 1'b1; s_rdata = 32'h8888_0000;
        step();
        s_ready = 1'b0; s_rdata = '0; m1_valid = 1'b0;
        step();
        @(negedge clock);
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
